mem_stage: RTL and testbench

- Memory-access stage of the 5-stage LoongArch pipeline, between execute and writeback.
- Registers the execute-to-memory bus and receives synchronous data-SRAM read data one cycle after the execute-stage request.
- Aligns and extends load data, forwards results and load/CSR hazards back to decode, and signals in-flight exceptions to execute so stores are suppressed.

---
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage LoongArch pipeline: holds the EX->MS bus,
// aligns synchronous SRAM load data, and forwards results/hazards to decode.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 205,
    parameter int MS_TO_WS_BUS_WD = 199,
    parameter int MS_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ms_flush_pipe,
    output logic                       ms_ex
);

    logic                       msValid_q, msValid_d;
    logic                       rbufValid_q, rbufValid_d;
    logic [31:0]                rbuf_q, rbuf_d;
    logic [ES_TO_MS_BUS_WD-1:0] busReg_q, busReg_d;
    logic                       msReadyGo;

    logic [31:0] msVaddr;
    logic [8:0]  msEsubcode;
    logic        msExFlag;
    logic        msErtn;
    logic [31:0] msCsrWvalue;
    logic [5:0]  msEcode;
    logic        msCsrRe;
    logic        msCsrWe;
    logic [13:0] msCsrNum;
    logic [31:0] msCsrWmask;
    logic [4:0]  msLoadOp;
    logic        msResFromMem;
    logic        msGrWe;
    logic [4:0]  msDest;
    logic [31:0] msResult;
    logic [31:0] msPc;

    logic [31:0] readData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;
    logic [31:0] finalResult;

    assign {msVaddr, msEsubcode, msExFlag, msErtn, msCsrWvalue, msEcode,
            msCsrRe, msCsrWe, msCsrNum, msCsrWmask, msLoadOp, msResFromMem,
            msGrWe, msDest, msResult, msPc} = busReg_q;

    assign msReadyGo      = 1'b1;
    assign ms_allowin     = !msValid_q || (msReadyGo && ws_allowin);
    assign ms_to_ws_valid = msValid_q && msReadyGo && !ms_flush_pipe;
    assign ms_ex          = msValid_q && (msExFlag || msErtn);

    // Flush wins over capture, so an instruction arriving with a flush is dropped.
    always_comb begin
        msValid_d = msValid_q;
        busReg_d  = busReg_q;
        if (ms_flush_pipe) begin
            msValid_d = 1'b0;
        end else if (ms_allowin) begin
            msValid_d = es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            busReg_d = es_to_ms_bus;
        end
    end

    // SRAM data is only valid the cycle after the request; hold it while stalled.
    always_comb begin
        rbufValid_d = rbufValid_q;
        rbuf_d      = rbuf_q;
        if (ms_flush_pipe || (msValid_q && ws_allowin)) begin
            rbufValid_d = 1'b0;
        end else if (msValid_q && msResFromMem && !rbufValid_q) begin
            rbufValid_d = 1'b1;
            rbuf_d      = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msValid_q   <= 1'b0;
            rbufValid_q <= 1'b0;
            rbuf_q      <= '0;
            busReg_q    <= '0;
        end else begin
            msValid_q   <= msValid_d;
            rbufValid_q <= rbufValid_d;
            rbuf_q      <= rbuf_d;
            busReg_q    <= busReg_d;
        end
    end

    assign readData = rbufValid_q ? rbuf_q : data_sram_rdata;

    always_comb begin
        loadByte = readData[7:0];
        case (msVaddr[1:0])
            2'd0:    loadByte = readData[7:0];
            2'd1:    loadByte = readData[15:8];
            2'd2:    loadByte = readData[23:16];
            default: loadByte = readData[31:24];
        endcase
        loadHalf = msVaddr[1] ? readData[31:16] : readData[15:0];
    end

    // A memory op with no load_op bit set behaves as a full-word load.
    always_comb begin
        loadData = readData;
        if (msLoadOp[0]) begin
            loadData = {{24{loadByte[7]}}, loadByte};
        end else if (msLoadOp[3]) begin
            loadData = {24'h0, loadByte};
        end else if (msLoadOp[1]) begin
            loadData = {{16{loadHalf[15]}}, loadHalf};
        end else if (msLoadOp[4]) begin
            loadData = {16'h0, loadHalf};
        end else if (msLoadOp[2] || (msLoadOp == 5'd0)) begin
            loadData = readData;
        end
    end

    assign finalResult = msResFromMem ? loadData : msResult;

    assign ms_to_ws_bus = {msVaddr, msEsubcode, msExFlag, msErtn, msCsrWvalue,
                           msEcode, msCsrRe, msCsrWe, msCsrNum, msCsrWmask,
                           msGrWe && !msExFlag, msDest, finalResult, msPc};

    assign ms_fwd_bus = {msValid_q && msCsrRe, msValid_q && msGrWe && !msExFlag,
                         msDest, finalResult};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// stall/flush/reset sequences and a randomized run against a reference model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [204:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [198:0] ms_to_ws_bus;
    logic [38:0]  ms_fwd_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_flush_pipe;
    logic         ms_ex;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] LDB  = 5'b00001;
    localparam logic [4:0] LDH  = 5'b00010;
    localparam logic [4:0] LDW  = 5'b00100;
    localparam logic [4:0] LDBU = 5'b01000;
    localparam logic [4:0] LDHU = 5'b10000;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_fwd_bus     (ms_fwd_bus),
        .data_sram_rdata(data_sram_rdata),
        .ms_flush_pipe  (ms_flush_pipe),
        .ms_ex          (ms_ex)
    );

    typedef struct packed {
        logic [31:0] vaddr;
        logic [8:0]  esubcode;
        logic        ex;
        logic        ertn;
        logic [31:0] csrWvalue;
        logic [5:0]  ecode;
        logic        csrRe;
        logic        csrWe;
        logic [13:0] csrNum;
        logic [31:0] csrWmask;
        logic [4:0]  loadOp;
        logic        resFromMem;
        logic        grWe;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } instrT;

    typedef struct packed {
        instrT       ins;
        logic [31:0] rdata;
        logic [31:0] expFinal;
        logic        expFwdValid;
        logic        expGrWe;
        logic        expEx;
    } vecT;

    function automatic instrT mkInstr(input logic [4:0] loadOp, input logic resFromMem,
                                      input logic [31:0] vaddr, input logic [31:0] result,
                                      input logic [4:0] dest, input logic grWe,
                                      input logic ex, input logic ertn, input logic csrRe);
        instrT i;
        i.vaddr      = vaddr;
        i.esubcode   = 9'h055;
        i.ex         = ex;
        i.ertn       = ertn;
        i.csrWvalue  = 32'h1357_9BDF;
        i.ecode      = 6'h2A;
        i.csrRe      = csrRe;
        i.csrWe      = 1'b1;
        i.csrNum     = 14'h1234;
        i.csrWmask   = 32'hF0F0_0F0F;
        i.loadOp     = loadOp;
        i.resFromMem = resFromMem;
        i.grWe       = grWe;
        i.dest       = dest;
        i.result     = result;
        i.pc         = 32'h1C00_0000 + vaddr;
        return i;
    endfunction

    function automatic vecT mkVec(input instrT ins, input logic [31:0] rdata,
                                  input logic [31:0] expFinal, input logic fv,
                                  input logic gw, input logic ex);
        vecT v;
        v.ins         = ins;
        v.rdata       = rdata;
        v.expFinal    = expFinal;
        v.expFwdValid = fv;
        v.expGrWe     = gw;
        v.expEx       = ex;
        return v;
    endfunction

    function automatic logic [204:0] packEs(input instrT i);
        return {i.vaddr, i.esubcode, i.ex, i.ertn, i.csrWvalue, i.ecode, i.csrRe,
                i.csrWe, i.csrNum, i.csrWmask, i.loadOp, i.resFromMem, i.grWe,
                i.dest, i.result, i.pc};
    endfunction

    function automatic logic [198:0] expWs(input instrT i, input logic grWe,
                                           input logic [31:0] fin);
        return {i.vaddr, i.esubcode, i.ex, i.ertn, i.csrWvalue, i.ecode, i.csrRe,
                i.csrWe, i.csrNum, i.csrWmask, grWe, i.dest, fin, i.pc};
    endfunction

    // Reference result: pick the addressed byte/half by shifting the word.
    function automatic logic [31:0] refFinal(input instrT i, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * i.vaddr[1:0]));
        h = 16'(word >> (16 * i.vaddr[1]));
        if (!i.resFromMem) return i.result;
        case (i.loadOp)
            LDB:     return {{24{b[7]}}, b};
            LDBU:    return {24'h0, b};
            LDH:     return {{16{h[15]}}, h};
            LDHU:    return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic instrT randInstr();
        instrT i;
        int    k;
        i.vaddr      = $urandom;
        i.esubcode   = 9'($urandom);
        i.ex         = ($urandom_range(0, 9) == 0);
        i.ertn       = ($urandom_range(0, 19) == 0);
        i.csrWvalue  = $urandom;
        i.ecode      = 6'($urandom);
        i.csrRe      = 1'($urandom_range(0, 1));
        i.csrWe      = 1'($urandom_range(0, 1));
        i.csrNum     = 14'($urandom);
        i.csrWmask   = $urandom;
        k            = int'($urandom_range(0, 5));
        i.loadOp     = (k == 0) ? 5'd0 : 5'(1 << (k - 1));
        i.resFromMem = 1'($urandom_range(0, 1));
        i.grWe       = 1'($urandom_range(0, 1));
        i.dest       = 5'($urandom);
        i.result     = $urandom;
        i.pc         = $urandom;
        return i;
    endfunction

    task automatic applyStimulus(input logic esValid, input logic [204:0] bus,
                                 input logic ws, input logic flush,
                                 input logic [31:0] rdata);
        @(negedge clk);
        es_to_ms_valid  = esValid;
        es_to_ms_bus    = bus;
        ws_allowin      = ws;
        ms_flush_pipe   = flush;
        data_sram_rdata = rdata;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [204:0] act,
                               input logic [204:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " ms_to_ws_valid"}, 205'(ms_to_ws_valid), 205'(1'b0));
        checkOutput({tag, " ms_ex"},          205'(ms_ex),          205'(1'b0));
        checkOutput({tag, " ms_fwd_bus"},     205'(ms_fwd_bus),     205'(39'h0));
        checkOutput({tag, " ms_allowin"},     205'(ms_allowin),     205'(1'b1));
    endtask

    // A load is killed (flush or reset) after its data was buffered; the next
    // load must buffer its own data rather than reuse the stale word.
    task automatic killDuringStall(input logic useReset);
        string tag;
        tag = useReset ? "resetStall" : "flushStall";
        applyStimulus(1'b1, packEs(mkInstr(LDW, 1'b1, 32'h4000, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0)),
                      1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'hAAAA_AAAA);
        applyStimulus(1'b0, '0, 1'b0, !useReset, 32'hAAAA_AAAA);
        if (useReset) reset = 1'b1;
        else checkOutput({tag, " flushValid"}, 205'(ms_to_ws_valid), 205'(1'b0));
        applyStimulus(1'b1, packEs(mkInstr(LDW, 1'b1, 32'h4008, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0)),
                      1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        checkOutput({tag, " killedValid"}, 205'(ms_to_ws_valid), 205'(1'b0));
        checkOutput({tag, " killedAllowin"}, 205'(ms_allowin), 205'(1'b1));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h5555_5555);
        checkOutput({tag, " newValid"}, 205'(ms_to_ws_valid), 205'(1'b1));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h6666_6666);
        checkOutput({tag, " newData"}, 205'(ms_fwd_bus[31:0]), 205'(32'h5555_5555));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        vecT         vec[15];
        instrT       ins, mIns, aluA;
        logic        mValid, mFirst, esV, ws, fl, allowNow;
        logic [31:0] mData, rd, fin;
        logic [4:0]  b2bOp[4];
        logic [31:0] b2bAddr[4], b2bData[4], b2bExp[4];

        vec[0]  = mkVec(mkInstr(LDB,  1, 32'h1003, 32'h0, 5'd3, 1, 0, 0, 0), 32'h80FF_1234, 32'hFFFF_FF80, 1, 1, 0);
        vec[1]  = mkVec(mkInstr(LDHU, 1, 32'h1002, 32'h0, 5'd4, 1, 0, 0, 0), 32'h80FF_1234, 32'h0000_80FF, 1, 1, 0);
        vec[2]  = mkVec(mkInstr(LDH,  1, 32'h1002, 32'h0, 5'd4, 1, 0, 0, 0), 32'h80FF_1234, 32'hFFFF_80FF, 1, 1, 0);
        vec[3]  = mkVec(mkInstr(LDBU, 1, 32'h1002, 32'h0, 5'd6, 1, 0, 0, 0), 32'h80FF_1234, 32'h0000_00FF, 1, 1, 0);
        vec[4]  = mkVec(mkInstr(LDB,  1, 32'h1001, 32'h0, 5'd6, 1, 0, 0, 0), 32'h80FF_1234, 32'h0000_0012, 1, 1, 0);
        vec[5]  = mkVec(mkInstr(LDB,  1, 32'h1000, 32'h0, 5'd7, 1, 0, 0, 0), 32'h0000_00F0, 32'hFFFF_FFF0, 1, 1, 0);
        vec[6]  = mkVec(mkInstr(LDH,  1, 32'h1000, 32'h0, 5'd8, 1, 0, 0, 0), 32'h1234_ABCD, 32'hFFFF_ABCD, 1, 1, 0);
        vec[7]  = mkVec(mkInstr(LDHU, 1, 32'h1000, 32'h0, 5'd8, 1, 0, 0, 0), 32'h1234_ABCD, 32'h0000_ABCD, 1, 1, 0);
        vec[8]  = mkVec(mkInstr(LDW,  1, 32'h2000, 32'h0, 5'd9, 1, 0, 0, 0), 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, 0);
        vec[9]  = mkVec(mkInstr(5'd0, 1, 32'h2002, 32'h0, 5'd9, 1, 0, 0, 0), 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1, 0);
        vec[10] = mkVec(mkInstr(5'd0, 0, 32'h0, 32'h42, 5'd5, 1, 0, 0, 0), 32'hFFFF_FFFF, 32'h0000_0042, 1, 1, 0);
        vec[11] = mkVec(mkInstr(5'd0, 0, 32'h0, 32'h42, 5'd5, 1, 1, 0, 0), 32'hFFFF_FFFF, 32'h0000_0042, 0, 0, 1);
        vec[12] = mkVec(mkInstr(5'd0, 0, 32'h0, 32'h77, 5'd0, 0, 0, 1, 0), 32'h0, 32'h0000_0077, 0, 0, 1);
        vec[13] = mkVec(mkInstr(5'd0, 0, 32'h0, 32'h1000, 5'd7, 1, 0, 0, 1), 32'h0, 32'h0000_1000, 1, 1, 0);
        vec[14] = mkVec(mkInstr(LDB,  0, 32'h1003, 32'h1234_5678, 5'd2, 1, 0, 0, 0), 32'h8080_8080, 32'h1234_5678, 1, 1, 0);

        reset           = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        ws_allowin      = 1'b1;
        ms_flush_pipe   = 1'b0;
        data_sram_rdata = 32'h0;

        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
        checkResetValues("reset");
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b1, packEs(vec[k].ins), 1'b1, 1'b0, 32'hDEAD_0000 + k);
            checkOutput($sformatf("vec%0d idleValid", k), 205'(ms_to_ws_valid), 205'(1'b0));
            applyStimulus(1'b0, '0, 1'b1, 1'b0, vec[k].rdata);
            checkOutput($sformatf("vec%0d valid", k), 205'(ms_to_ws_valid), 205'(1'b1));
            checkOutput($sformatf("vec%0d ms_ex", k), 205'(ms_ex), 205'(vec[k].expEx));
            checkOutput($sformatf("vec%0d fwd", k), 205'(ms_fwd_bus),
                        205'({vec[k].ins.csrRe, vec[k].expFwdValid, vec[k].ins.dest, vec[k].expFinal}));
            checkOutput($sformatf("vec%0d wsBus", k), 205'(ms_to_ws_bus),
                        205'(expWs(vec[k].ins, vec[k].expGrWe, vec[k].expFinal)));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);

        $display("[TB] load stall with changing SRAM data");
        applyStimulus(1'b1, packEs(mkInstr(LDW, 1, 32'h3000, 32'h0, 5'd1, 1, 0, 0, 0)), 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h1111_1111);
        checkOutput("stall allowin", 205'(ms_allowin), 205'(1'b0));
        checkOutput("stall valid", 205'(ms_to_ws_valid), 205'(1'b1));
        checkOutput("stall data1", 205'(ms_fwd_bus[31:0]), 205'(32'h1111_1111));
        for (int c = 2; c <= 3; c++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h2222_2222);
            checkOutput($sformatf("stall data%0d", c), 205'(ms_fwd_bus[31:0]), 205'(32'h1111_1111));
        end
        applyStimulus(1'b1, packEs(mkInstr(LDW, 1, 32'h3004, 32'h0, 5'd2, 1, 0, 0, 0)), 1'b1, 1'b0, 32'h2222_2222);
        checkOutput("stall release", 205'(ms_fwd_bus[31:0]), 205'(32'h1111_1111));
        checkOutput("stall releaseAllowin", 205'(ms_allowin), 205'(1'b1));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h3333_3333);
        checkOutput("stall nextLoad", 205'(ms_fwd_bus[31:0]), 205'(32'h3333_3333));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);

        $display("[TB] flush with simultaneous capture");
        aluA = mkInstr(5'd0, 0, 32'h0, 32'h42, 5'd5, 1, 0, 0, 0);
        applyStimulus(1'b1, packEs(aluA), 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, packEs(mkInstr(5'd0, 0, 32'h0, 32'h99, 5'd6, 1, 1, 0, 1)), 1'b1, 1'b1, 32'h0);
        checkOutput("flush valid", 205'(ms_to_ws_valid), 205'(1'b0));
        checkOutput("flush fwdStill", 205'(ms_fwd_bus), 205'({1'b0, 1'b1, 5'd5, 32'h42}));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush nextValid", 205'(ms_to_ws_valid), 205'(1'b0));
        checkOutput("flush nextEx", 205'(ms_ex), 205'(1'b0));
        checkOutput("flush nextFwdFlags", 205'(ms_fwd_bus[38:37]), 205'(2'b00));

        killDuringStall(1'b0);
        killDuringStall(1'b1);

        $display("[TB] back-to-back loads then reset mid-stream");
        b2bOp   = '{LDW, LDB, LDHU, LDH};
        b2bAddr = '{32'h5000, 32'h5001, 32'h5002, 32'h5002};
        b2bData = '{32'hA5A5_1234, 32'h0000_8000, 32'hF00D_0000, 32'h8000_0000};
        b2bExp  = '{32'hA5A5_1234, 32'hFFFF_FF80, 32'h0000_F00D, 32'hFFFF_8000};
        applyStimulus(1'b1, packEs(mkInstr(b2bOp[0], 1, b2bAddr[0], 32'h0, 5'd11, 1, 0, 0, 0)),
                      1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            ins = mkInstr(b2bOp[k % 4], 1, b2bAddr[k % 4], 32'h0, 5'(11 + k), 1, 0, 0, 0);
            applyStimulus(1'b1, packEs(ins), 1'b1, 1'b0, b2bData[k - 1]);
            checkOutput($sformatf("b2b%0d allowin", k - 1), 205'(ms_allowin), 205'(1'b1));
            checkOutput($sformatf("b2b%0d valid", k - 1), 205'(ms_to_ws_valid), 205'(1'b1));
            checkOutput($sformatf("b2b%0d data", k - 1), 205'(ms_fwd_bus[31:0]), 205'(b2bExp[k - 1]));
        end
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        checkResetValues("midReset");
        reset = 1'b0;

        $display("[TB] randomized run against reference model");
        mValid = 1'b0;
        mFirst = 1'b0;
        mIns   = '0;
        mData  = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            esV = ($urandom_range(0, 9) < 6);
            ws  = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 19) == 0);
            rd  = $urandom;
            ins = randInstr();
            applyStimulus(esV, packEs(ins), ws, fl, rd);
            if (mValid && mFirst) begin
                mData  = rd;
                mFirst = 1'b0;
            end
            fin = refFinal(mIns, mData);
            checkOutput($sformatf("rnd%0d valid", n), 205'(ms_to_ws_valid), 205'(mValid && !fl));
            checkOutput($sformatf("rnd%0d allowin", n), 205'(ms_allowin), 205'(!mValid || ws));
            checkOutput($sformatf("rnd%0d ex", n), 205'(ms_ex), 205'(mValid && (mIns.ex || mIns.ertn)));
            checkOutput($sformatf("rnd%0d fwdFlags", n), 205'(ms_fwd_bus[38:37]),
                        205'({mValid && mIns.csrRe, mValid && mIns.grWe && !mIns.ex}));
            if (mValid) begin
                checkOutput($sformatf("rnd%0d fwdData", n), 205'(ms_fwd_bus[36:0]), 205'({mIns.dest, fin}));
                checkOutput($sformatf("rnd%0d wsBus", n), 205'(ms_to_ws_bus),
                            205'(expWs(mIns, mIns.grWe && !mIns.ex, fin)));
            end
            allowNow = !mValid || ws;
            if (fl) begin
                mValid = 1'b0;
            end else if (allowNow) begin
                mValid = esV;
                if (esV) begin
                    mIns   = ins;
                    mFirst = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
